// File: rtl/ccg_bist_pkg.sv
// ccg_bist_pkg: shared types and helpers for the CCGRCG BIST harness.
//   state_t          - sweep controller states
//   CCG_MISR_TAPS_20 - default Galois taps for x^20 + x^3 + 1
//   misr_step()      - one Galois left-shift MISR step, width given at call time
package ccg_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [19:0] CCG_MISR_TAPS_20 = 20'h00009;

    // Widest MISR the helper supports; narrower registers are zero-extended.
    localparam int unsigned MISR_MAX_W = 32;

    // next[i] = misr[i-1] ^ (msb & taps[i]) ^ f[i]; next[0] has no shift-in.
    // Bits at or above `width` are forced to zero.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] misr,
        input logic [MISR_MAX_W-1:0] f,
        input logic [MISR_MAX_W-1:0] taps,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] top_bit;
        logic [MISR_MAX_W-1:0] mask;
        logic                  msb;
        top_bit = MISR_MAX_W'(1) << (width - 1);
        // Wraps to all-ones when width == MISR_MAX_W.
        mask    = (top_bit << 1) - MISR_MAX_W'(1);
        msb     = |(misr & top_bit);
        return ((misr << 1) ^ ({MISR_MAX_W{msb}} & taps) ^ f) & mask;
    endfunction

endpackage

// File: rtl/ccg_misr.sv
// ccg_misr: Galois multiple-input signature register.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, loads SEED
//   init - synchronous reload of SEED (wins over en)
//   en   - compact d into the register this cycle
//   d    - parallel response word
//   q    - current signature
module ccg_misr
    import ccg_bist_pkg::*;
#(
    parameter int unsigned         WIDTH = 20,
    parameter logic [WIDTH-1:0]    TAPS  = CCG_MISR_TAPS_20,
    parameter logic [WIDTH-1:0]    SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0]      misr_q;
    logic [WIDTH-1:0]      misr_d;
    logic [MISR_MAX_W-1:0] step_wide;

    assign step_wide = misr_step(MISR_MAX_W'(misr_q), MISR_MAX_W'(d), MISR_MAX_W'(TAPS), WIDTH);

    always_comb begin
        misr_d = misr_q;
        if (init) begin
            misr_d = SEED;
        end else if (en) begin
            misr_d = step_wide[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr_q <= SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign q = misr_q;

endmodule

// File: rtl/ccg_bist_harness.sv
// ccg_bist_harness: exhaustive-stimulus / signature-compaction harness for the
// 4-input, 20-output CCGRCG combinational benchmarks.
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   start     - begin a sweep (honoured only in IDLE or DONE)
//   hold      - freeze the sweep while in RUN
//   x         - registered CUT stimulus, x[0] drives x0
//   f         - CUT response, f[0] is f1
//   busy      - high in RUN
//   done      - high in DONE
//   pass      - done and signature equals GOLDEN_SIG
//   signature - current MISR contents
module ccg_bist_harness
    import ccg_bist_pkg::*;
#(
    parameter int unsigned      IN_W       = 4,
    parameter int unsigned      OUT_W      = 20,
    parameter logic [OUT_W-1:0] MISR_TAPS  = 20'h00009,
    parameter logic [OUT_W-1:0] MISR_SEED  = 20'h00000,
    parameter logic [OUT_W-1:0] GOLDEN_SIG = 20'h00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic [IN_W-1:0]  x,
    input  logic [OUT_W-1:0] f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature
);

    localparam logic [IN_W-1:0] X_LAST = '1;

    state_t          state_q, state_d;
    logic [IN_W-1:0] x_q, x_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            misr_init;
    logic            misr_en;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        misr_init = 1'b0;
        misr_en   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    x_d       = '0;
                    misr_init = 1'b1;
                end
            end
            RUN: begin
                if (!hold) begin
                    misr_en = 1'b1;
                    // Last vector parks x instead of wrapping.
                    if (x_q == X_LAST) begin
                        state_d = DONE;
                    end else begin
                        x_d = x_q + IN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    ccg_misr #(
        .WIDTH (OUT_W),
        .TAPS  (MISR_TAPS),
        .SEED  (MISR_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .init (misr_init),
        .en   (misr_en),
        .d    (f),
        .q    (signature)
    );

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;
    // Registers only: no path from f or start.
    assign pass = done_q && (signature == GOLDEN_SIG);

endmodule

// File: tb/tb_ccg_bist_harness.sv
// tb_ccg_bist_harness: table-driven bench for ccg_bist_harness with a CUT stub
// that returns a chosen word on one vector and zero elsewhere.
module tb_ccg_bist_harness;

    localparam logic [19:0] TAPS = 20'h00009;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic [3:0]  x;
    logic [19:0] f;
    logic        busy;
    logic        done;
    logic        pass;
    logic [19:0] signature;

    int          stub_hit;
    logic [19:0] stub_word;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign f = (stub_hit >= 0 && int'(x) == stub_hit) ? stub_word : 20'h0;

    ccg_bist_harness dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hold      (hold),
        .x         (x),
        .f         (f),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    typedef struct {
        string       name;
        int          hit_x;
        logic [19:0] word;
        int          hold_at;
        int          hold_len;
        bit          start_in_run;
        logic [19:0] exp_sig;
        bit          exp_pass;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent bit-level reference of the MISR step.
    function automatic logic [19:0] ref_step(input logic [19:0] m, input logic [19:0] fv);
        logic [19:0] n;
        n[0] = (m[19] & TAPS[0]) ^ fv[0];
        for (int i = 1; i < 20; i++) begin
            n[i] = m[i-1] ^ (m[19] & TAPS[i]) ^ fv[i];
        end
        return n;
    endfunction

    function automatic logic [19:0] ref_sig(input int hit_x, input logic [19:0] word);
        logic [19:0] m;
        m = 20'h0;
        for (int k = 0; k < 16; k++) begin
            m = ref_step(m, (k == hit_x) ? word : 20'h0);
        end
        return m;
    endfunction

    // Pulses start, walks the sweep checking x/busy each cycle, returns the
    // cycle index (start edge = 0) at which done is first seen.
    task automatic sweep(input int hold_at, input int hold_len, input bit start_in_run,
                         output int lat);
        int exp_x;
        int held;
        exp_x = 0;
        held  = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        hold  = (hold_at == 0 && hold_len > 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 60) begin
            check("busy_in_run", 32'(busy), 32'd1);
            check("x_in_run", 32'(x), 32'(exp_x));
            if (exp_x == hold_at && held < hold_len) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = 1'b0;
                if (exp_x < 15) exp_x++;
            end
            start = start_in_run && lat >= 3 && lat <= 5;
            @(posedge clk);
            #1;
            lat++;
        end
        hold  = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int          lat;
        int          n;
        logic [19:0] sig_snap;

        tbl[0] = '{"zero",        -1, 20'h00000, -1, 0, 1'b0, 20'h00000, 1'b1};
        tbl[1] = '{"hit_v0",       0, 20'h00001, -1, 0, 1'b0, 20'h08000, 1'b0};
        tbl[2] = '{"hit_v15",     15, 20'h00001, -1, 0, 1'b0, 20'h00001, 1'b0};
        tbl[3] = '{"fb_v0",        0, 20'h80000, -1, 0, 1'b0, 20'h24000, 1'b0};
        tbl[4] = '{"fb_v7",        7, 20'h80000, -1, 0, 1'b0, 20'h00480, 1'b0};
        tbl[5] = '{"hold_x5",      0, 20'h00001,  5, 3, 1'b0, 20'h08000, 1'b0};
        tbl[6] = '{"hold_x0_st",  15, 20'hABCDE,  0, 2, 1'b1, 20'hABCDE, 1'b0};
        tbl[7] = '{"hold_x15",    15, 20'h00001, 15, 2, 1'b0, 20'h00001, 1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        hold      = 1'b0;
        stub_hit  = -1;
        stub_word = 20'h0;
        #12;
        check("rst_x", 32'(x), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Idle with a nonzero response must not disturb anything.
        stub_hit  = 0;
        stub_word = 20'hFFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("idle_sig", 32'(signature), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            stub_hit  = tbl[i].hit_x;
            stub_word = tbl[i].word;
            sweep(tbl[i].hold_at, tbl[i].hold_len, tbl[i].start_in_run, lat);
            check({tbl[i].name, "_latency"}, 32'(lat), 32'(17 + tbl[i].hold_len));
            check({tbl[i].name, "_done"}, 32'(done), 32'd1);
            check({tbl[i].name, "_busy"}, 32'(busy), 32'd0);
            check({tbl[i].name, "_sig"}, 32'(signature), 32'(tbl[i].exp_sig));
            check({tbl[i].name, "_sig_model"}, 32'(signature),
                  32'(ref_sig(tbl[i].hit_x, tbl[i].word)));
            check({tbl[i].name, "_pass"}, 32'(pass), 32'(tbl[i].exp_pass));
            check({tbl[i].name, "_x_last"}, 32'(x), 32'd15);
            // Result stays put in DONE while f keeps toggling between vectors.
            stub_hit  = 15;
            stub_word = 20'h5A5A5;
            repeat (3) @(posedge clk);
            #1;
            check({tbl[i].name, "_done_hold_sig"}, 32'(signature), 32'(tbl[i].exp_sig));
            check({tbl[i].name, "_done_hold"}, 32'(done), 32'd1);
        end

        // Reset in the middle of a sweep, at x == 9.
        stub_hit  = 0;
        stub_word = 20'h00001;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (x !== 4'd9 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrun_reach_x9", 32'(x), 32'd9);
        check("midrun_sig_x9", 32'(signature), 32'h00100);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_x", 32'(x), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_pass", 32'(pass), 32'd0);
        check("async_rst_sig", 32'(signature), 32'd0);
        #2;
        rst = 1'b0;
        sweep(-1, 0, 1'b1, lat);
        check("post_rst_latency", 32'(lat), 32'd17);
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_sig", 32'(signature), 32'h08000);
        check("post_rst_pass", 32'(pass), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
